// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
// Groups the line-control, serial input and received-frame status signals
// exchanged between the APB UART glue (master) and the receive engine (slave).
//   RXCLK      16x baud enable, one CLK wide per tick
//   CLEAR      synchronous abort of the frame in progress
//   WLS/STB/PEN/EPS/SP  line control straight from the LCR
//   SIN        serial input, idle high
//   DOUT/PE/FE/BI      received word and status of the last frame
//   RXFINISHED one-CLK strobe when a frame completes
// ---------------------------------------------------------------------------
interface uart_receiver_if;
    logic       RXCLK;
    logic       CLEAR;
    logic [1:0] WLS;
    logic       STB;
    logic       PEN;
    logic       EPS;
    logic       SP;
    logic       SIN;
    logic [7:0] DOUT;
    logic       PE;
    logic       FE;
    logic       BI;
    logic       RXFINISHED;

    modport master (
        output RXCLK, CLEAR, WLS, STB, PEN, EPS, SP, SIN,
        input  DOUT, PE, FE, BI, RXFINISHED
    );

    modport slave (
        input  RXCLK, CLEAR, WLS, STB, PEN, EPS, SP, SIN,
        output DOUT, PE, FE, BI, RXFINISHED
    );
endinterface

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// Serial-to-parallel receive engine of the APB UART. Synchronises SIN,
// detects the start edge, samples start/data/parity/stop mid-bit using the
// 16x RXCLK enable and presents the word with PE/FE/BI and a one-CLK
// RXFINISHED strobe.
// Ports:
//   CLK    system clock
//   RST    asynchronous active-high reset
//   rx_if  uart_receiver_if.slave (RXCLK, CLEAR, LCR fields, SIN in;
//          DOUT, PE, FE, BI, RXFINISHED out)
// Parameters:
//   SYNC_STAGES  flops in the SIN synchroniser (values below 2 use 2)
// Build option:
//   RX_MAJORITY_EN  when defined, each bit is the 2-of-3 vote of samples
//                   taken at cnt==6,7,8 and decided at cnt==8; otherwise a
//                   single sample at cnt==7 is used.
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    uart_receiver_if.slave  rx_if
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

`ifdef RX_MAJORITY_EN
    localparam logic [3:0] SAMPLE_CNT = 4'd8;
`else
    localparam logic [3:0] SAMPLE_CNT = 4'd7;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    function automatic logic [7:0] word_mask(input logic [1:0] wls);
        case (wls)
            2'b00:   word_mask = 8'h1F;
            2'b01:   word_mask = 8'h3F;
            2'b10:   word_mask = 8'h7F;
            2'b11:   word_mask = 8'hFF;
            default: word_mask = 8'hFF;
        endcase
    endfunction

    // Expected parity bit: stick parity forces ~EPS, otherwise even/odd over
    // the active data bits only.
    function automatic logic exp_parity(input logic [7:0] data, input logic [1:0] wls,
                                        input logic eps, input logic sp);
        logic x;
        x = ^(data & word_mask(wls));
        if (sp) begin
            exp_parity = ~eps;
        end else if (eps) begin
            exp_parity = x;
        end else begin
            exp_parity = ~x;
        end
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    logic [SS-1:0] sync_q;
    logic          s_sin;
    logic          prev_q;
    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    data_sh_q;
    logic          pe_sh_q;
    logic          fe_sh_q;
    logic          bi_sh_q;
    logic          zero_q;      // every data/parity bit so far was 0
    logic          pend_q;      // stop sampled, publish on the next CLK
    logic [7:0]    dout_q;
    logic          pe_q;
    logic          fe_q;
    logic          bi_q;
    logic          rxfin_q;
    logic          samp_d;
    logic          bit_d;
    logic [2:0]    last_idx_d;
    logic          stb_unused_d;

    assign s_sin        = sync_q[SS-1];
    assign stb_unused_d = rx_if.STB;    // only the first stop bit is checked

`ifdef RX_MAJORITY_EN
    logic v6_q;
    logic v7_q;

    // Capture the two early votes of the current bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v6_q <= 1'b1;
            v7_q <= 1'b1;
        end else if (rx_if.RXCLK && (cnt_q == 4'd6)) begin
            v6_q <= s_sin;
        end else if (rx_if.RXCLK && (cnt_q == 4'd7)) begin
            v7_q <= s_sin;
        end else begin
            v6_q <= v6_q;
        end
    end
`endif

    // Sample point and decided bit value.
    always_comb begin
        samp_d     = rx_if.RXCLK && (cnt_q == SAMPLE_CNT);
`ifdef RX_MAJORITY_EN
        bit_d      = maj3(v6_q, v7_q, s_sin);
`else
        bit_d      = s_sin;
`endif
        last_idx_d = {1'b0, rx_if.WLS} + 3'd4;
    end

    // SIN metastability synchroniser, idles high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SS-2:0], rx_if.SIN};
        end
    end

    // Receive FSM with tick counter, shadow status and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= 3'd0;
            data_sh_q <= 8'h00;
            pe_sh_q   <= 1'b0;
            fe_sh_q   <= 1'b0;
            bi_sh_q   <= 1'b0;
            zero_q    <= 1'b1;
            pend_q    <= 1'b0;
            dout_q    <= 8'h00;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
            rxfin_q   <= 1'b0;
        end else begin
            prev_q  <= s_sin;
            rxfin_q <= 1'b0;
            if (rx_if.CLEAR) begin
                // Abort wins over any sample point; published outputs persist.
                state_q   <= IDLE;
                cnt_q     <= 4'd0;
                idx_q     <= 3'd0;
                data_sh_q <= 8'h00;
                pe_sh_q   <= 1'b0;
                fe_sh_q   <= 1'b0;
                bi_sh_q   <= 1'b0;
                zero_q    <= 1'b1;
                pend_q    <= 1'b0;
            end else if (pend_q) begin
                dout_q  <= data_sh_q;
                pe_q    <= pe_sh_q;
                fe_q    <= fe_sh_q;
                bi_q    <= bi_sh_q;
                rxfin_q <= 1'b1;
                pend_q  <= 1'b0;
                state_q <= IDLE;
            end else begin
                if (rx_if.RXCLK) begin
                    cnt_q <= cnt_q + 4'd1;
                end else begin
                    cnt_q <= cnt_q;
                end
                case (state_q)
                    IDLE: begin
                        // Only a real 1->0 transition starts a frame.
                        if (prev_q && !s_sin) begin
                            state_q <= START;
                            cnt_q   <= 4'd0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    START: begin
                        if (samp_d && bit_d) begin
                            state_q <= IDLE;
                        end else if (samp_d) begin
                            state_q   <= DATA;
                            idx_q     <= 3'd0;
                            data_sh_q <= 8'h00;
                            pe_sh_q   <= 1'b0;
                            fe_sh_q   <= 1'b0;
                            bi_sh_q   <= 1'b0;
                            zero_q    <= 1'b1;
                        end else begin
                            state_q <= START;
                        end
                    end
                    DATA: begin
                        if (samp_d) begin
                            data_sh_q[idx_q] <= bit_d;
                            zero_q           <= zero_q & ~bit_d;
                            if (idx_q >= last_idx_d) begin
                                state_q <= rx_if.PEN ? PAR : STOP;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    PAR: begin
                        if (samp_d) begin
                            pe_sh_q <= bit_d ^ exp_parity(data_sh_q, rx_if.WLS, rx_if.EPS, rx_if.SP);
                            zero_q  <= zero_q & ~bit_d;
                            state_q <= STOP;
                        end else begin
                            state_q <= PAR;
                        end
                    end
                    STOP: begin
                        if (samp_d) begin
                            fe_sh_q <= ~bit_d;
                            bi_sh_q <= zero_q & ~bit_d;
                            pend_q  <= 1'b1;
                        end else begin
                            state_q <= STOP;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_if.DOUT       = dout_q;
    assign rx_if.PE         = pe_q;
    assign rx_if.FE         = fe_q;
    assign rx_if.BI         = bi_q;
    assign rx_if.RXFINISHED = rxfin_q;

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
// Self-checking bench for uart_receiver: table of frames plus hand-written
// glitch, break and abort sequences; expected status is queued when a frame
// is sent and compared when RXFINISHED pulses.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    typedef struct {
        logic [7:0] dout;
        logic       pe;
        logic       fe;
        logic       bi;
    } exp_t;

    typedef struct {
        logic [1:0] wls;
        logic       pen;
        logic       eps;
        logic       sp;
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] e_dout;
        logic       e_pe;
        logic       e_fe;
        logic       e_bi;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   strobe_cnt;
    int   exp_cnt;
    exp_t sb_q[$];
    exp_t last_exp;
    vec_t vecs[8];

    uart_receiver_if rx_if ();

    uart_receiver #(.SYNC_STAGES(2)) dut (
        .CLK   (clk),
        .RST   (rst),
        .rx_if (rx_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every strobe against the oldest queued frame.
    always @(negedge clk) begin
        if (rx_if.RXFINISHED === 1'b1) begin
            strobe_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe with empty queue expected none");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("dout", {24'd0, rx_if.DOUT}, {24'd0, e.dout});
                chk("pe", {31'd0, rx_if.PE}, {31'd0, e.pe});
                chk("fe", {31'd0, rx_if.FE}, {31'd0, e.fe});
                chk("bi", {31'd0, rx_if.BI}, {31'd0, e.bi});
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk); #1 rx_if.RXCLK = 1'b1;
            @(posedge clk); #1 rx_if.RXCLK = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx_if.SIN = b;
        tick_n(16);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe, input logic bi);
        exp_t e;
        e.dout = d; e.pe = pe; e.fe = fe; e.bi = bi;
        sb_q.push_back(e);
        last_exp = e;
        exp_cnt++;
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                              input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
        if (pen) send_bit(par);
        send_bit(stop);
        rx_if.SIN = 1'b1;
        tick_n(8);
    endtask

    task automatic set_lcr(input logic [1:0] wls, input logic pen, input logic eps, input logic sp);
        rx_if.WLS = wls; rx_if.PEN = pen; rx_if.EPS = eps; rx_if.SP = sp;
    endtask

    initial begin
        checks = 0; errors = 0; strobe_cnt = 0; exp_cnt = 0;
        last_exp = '{8'h00, 1'b0, 1'b0, 1'b0};
        rst = 1'b1;
        rx_if.RXCLK = 1'b0; rx_if.CLEAR = 1'b0; rx_if.STB = 1'b0;
        rx_if.SIN = 1'b1;
        set_lcr(2'd3, 1'b0, 1'b0, 1'b0);

        //            wls   pen   eps   sp    data   par   stop  dout   pe    fe    bi
        vecs[0] = '{2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'd0, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'd2, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'd2, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{2'd3, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{2'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", {24'd0, rx_if.DOUT}, 32'd0);
        chk("rst_flags", {28'd0, rx_if.PE, rx_if.FE, rx_if.BI, rx_if.RXFINISHED}, 32'd0);
        rst = 1'b0;
        tick_n(4);

        // Table-driven frames.
        for (int v = 0; v < 8; v++) begin
            set_lcr(vecs[v].wls, vecs[v].pen, vecs[v].eps, vecs[v].sp);
            push_exp(vecs[v].e_dout, vecs[v].e_pe, vecs[v].e_fe, vecs[v].e_bi);
            send_frame(vecs[v].data, int'(vecs[v].wls) + 5, vecs[v].pen, vecs[v].par, vecs[v].stop);
            chk("strobe_count_tbl", strobe_cnt, exp_cnt);
        end

        // Start glitch: 4 ticks low must not produce a frame.
        set_lcr(2'd3, 1'b0, 1'b0, 1'b0);
        rx_if.SIN = 1'b0;
        tick_n(4);
        rx_if.SIN = 1'b1;
        tick_n(40);
        chk("glitch_no_strobe", strobe_cnt, exp_cnt);
        push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        chk("strobe_count_3c", strobe_cnt, exp_cnt);

        // Break: line low for 200 ticks gives exactly one frame.
        push_exp(8'h00, 1'b0, 1'b1, 1'b1);
        rx_if.SIN = 1'b0;
        tick_n(200);
        chk("break_one_strobe", strobe_cnt, exp_cnt);
        rx_if.SIN = 1'b1;
        tick_n(20);
        chk("break_no_second", strobe_cnt, exp_cnt);
        push_exp(8'h81, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        chk("strobe_count_81", strobe_cnt, exp_cnt);

        // CLEAR mid-frame (bit 3 of 0x55); sender then goes idle.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx_if.SIN = 1'b0;
        tick_n(8);
        @(posedge clk); #1 rx_if.CLEAR = 1'b1;
        @(posedge clk); #1 rx_if.CLEAR = 1'b0;
        tick_n(8);
        rx_if.SIN = 1'b1;
        tick_n(200);
        chk("clear_no_strobe", strobe_cnt, exp_cnt);
        chk("clear_hold_dout", {24'd0, rx_if.DOUT}, {24'd0, last_exp.dout});
        chk("clear_hold_flags", {29'd0, rx_if.PE, rx_if.FE, rx_if.BI},
            {29'd0, last_exp.pe, last_exp.fe, last_exp.bi});
        push_exp(8'hC3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
        chk("strobe_count_c3", strobe_cnt, exp_cnt);

        tick_n(10);
        chk("queue_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel receive engine for the APB UART; the counterpart of the UART transmit engine. Samples SIN using a 16x-baud enable (RXCLK) and recovers start, 5-8 data, optional parity and stop bits. Presents the received word plus parity, framing and break status to the RX FIFO / LSR logic with a one-cycle RXFINISHED strobe. Line-control inputs (WLS, PEN, EPS, SP, STB) come straight from the LCR.

Parameters:
SYNC_STAGES, 2, number of flops in the SIN metastability synchronizer (min 2)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
RXCLK  in  1  16x baud enable, one CLK wide per tick
CLEAR  in  1  synchronous abort: return to IDLE, discard frame in progress
WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
STB  in  1  stop bits (receiver checks first stop only)
PEN  in  1  parity enable
EPS  in  1  even parity select
SP  in  1  stick parity
SIN  in  1  serial input, idle high
DOUT  out  8  received word, LSB first on line, unused upper bits 0
PE  out  1  parity error of last frame
FE  out  1  framing error (stop sampled 0)
BI  out  1  break: data, parity and stop all 0
RXFINISHED  out  1  one-CLK strobe, frame complete

Behaviour:
- Reset: RST=1, asynchronous, active-high; clock CLK. All synchronizer flops reset to 1; state IDLE; DOUT=0, PE=0, FE=0, BI=0, RXFINISHED=0; tick counter 0; previous-sample flag 1.
- sSIN = synchronized SIN (SYNC_STAGES flops on CLK). All decisions use sSIN only.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: start detected on falling edge of sSIN (prev 1, now 0) -> START, 4-bit tick counter cnt cleared. A level-low line without a preceding high does not start a frame.
- cnt increments on every RXCLK tick and wraps 15->0. Sample point is the tick at which cnt==7 (8th tick after detect, mid-bit).
- START: at sample point, sSIN=1 -> IDLE (glitch, no strobe); sSIN=0 -> DATA, bit index 0.
- DATA: at each sample point shift sSIN into DOUT shadow at bit index; after bit WLS+4 -> PAR if PEN=1 else STOP.
- PAR: expected bit = SP ? ~EPS : (EPS ? XOR(data) : ~XOR(data)), XOR over the WLS-selected bits only. Mismatch sets PE shadow. -> STOP.
- STOP: at sample point, FE shadow = ~sSIN; BI shadow = all data bits 0, parity bit 0 (if PEN), stop 0. Next CLK: DOUT/PE/FE/BI outputs load shadows, RXFINISHED=1 for exactly one CLK, state -> IDLE. STB ignored (second stop not checked); a new start may be detected immediately from IDLE.
- Outputs hold until next RXFINISHED; not cleared by CLEAR.
- CLEAR=1: state -> IDLE, cnt=0, shadows cleared, no RXFINISHED; CLEAR wins over a simultaneous sample point.
- WLS/PEN/EPS/SP changes mid-frame: undefined frame content, FSM must still terminate in IDLE.
- RXCLK stuck 0: FSM holds state indefinitely; no timeout.

Optional Feature:
Macro RX_MAJORITY_EN. Defined: each bit value is the 2-of-3 majority of sSIN captured on ticks cnt==6,7,8; decision taken at cnt==8 (all transitions and RXFINISHED one tick later than without macro); start validation uses the same vote. Undefined: single sample at cnt==7 as above.

Test Plan:
- WLS=11, PEN=0, send 0xA5 8N1 at 16 ticks/bit -> one RXFINISHED, DOUT=0xA5, PE=0, FE=0, BI=0.
- WLS=00, PEN=1, EPS=1, send 0x13 with parity bit 0 (should be 1) -> DOUT=0x13, PE=1, FE=0.
- WLS=10, PEN=1, SP=1, EPS=0, send 0x7F with parity 1 -> PE=0; repeat with parity 0 -> PE=1.
- SIN low for 4 ticks then high -> no RXFINISHED, state returns IDLE; next valid 0x3C received correctly.
- SIN held low 200 ticks (WLS=11, PEN=0) -> exactly one RXFINISHED, DOUT=0x00, FE=1, BI=1; second frame only after SIN returns high then falls.
- CLEAR pulsed during bit 3 of 0x55 -> no RXFINISHED, outputs keep previous frame values; following 0xC3 received as DOUT=0xC3.
